// File: rtl/word_packer_pkg.sv
// Shared types and helpers for the byte-to-word packer.
package word_packer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_OUT,
        ST_BOTH
    } state_t;

    // Arrival position 0 lands in the most significant lane.
    function automatic int lane_idx(input int nbytes, input int pos);
        return nbytes - 1 - pos;
    endfunction

endpackage

// File: rtl/word_lane_fill.sv
// Builds the outgoing word: first cnt lanes from acc (MSB first), the rest PAD.
module word_lane_fill
    import word_packer_pkg::*;
#(
    parameter int          NBYTES = 4,
    parameter logic [7:0]  PAD    = 8'h00,
    parameter int          CW     = 3
) (
    input  logic [BYTE_W*NBYTES-1:0] acc,
    input  logic [CW-1:0]            cnt,
    output logic [BYTE_W*NBYTES-1:0] word
);

    always_comb begin
        word = '0;
        for (int p = 0; p < NBYTES; p++) begin
            if (p < int'(cnt)) begin
                word[lane_idx(NBYTES, p)*BYTE_W +: BYTE_W] =
                    acc[lane_idx(NBYTES, p)*BYTE_W +: BYTE_W];
            end else begin
                word[lane_idx(NBYTES, p)*BYTE_W +: BYTE_W] = PAD;
            end
        end
    end

endmodule

// File: rtl/word_packer.sv
// Packs a valid/ready byte stream into words, MSB byte first, with a
// one-word holding slot behind the output register.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int         NBYTES = 4,
    parameter logic [7:0] PAD    = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [BYTE_W*NBYTES-1:0] dout,
    output logic [2:0]               out_bytes,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nx;
    logic [W-1:0]  word;
    logic [W-1:0]  hold;
    logic [2:0]    hold_bytes;
    logic [2:0]    word_bytes;
    logic          take;
    logic          done;
    logic          out_xfer;

    always_comb begin
        take     = in_valid & in_ready;
        out_xfer = out_valid & out_ready;
        cnt_nx   = cnt + {{(CW-1){1'b0}}, take};
        acc_nx   = acc;
        if (take) begin
            acc_nx[lane_idx(NBYTES, int'(cnt))*BYTE_W +: BYTE_W] = in_data;
        end
        word_bytes = 3'(cnt_nx);
        // A same-cycle byte is counted before flush decides to close the word.
        done = (take && int'(cnt_nx) == NBYTES) ||
               (flush && cnt_nx != '0 && state != ST_BOTH);
    end

    word_lane_fill #(
        .NBYTES (NBYTES),
        .PAD    (PAD),
        .CW     (CW)
    ) u_fill (
        .acc  (acc_nx),
        .cnt  (cnt_nx),
        .word (word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_EMPTY;
            cnt        <= '0;
            acc        <= '0;
            hold       <= '0;
            hold_bytes <= '0;
            dout       <= '0;
            out_bytes  <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            if (done) begin
                cnt <= '0;
                acc <= '0;
            end else if (take) begin
                cnt <= cnt_nx;
                acc <= acc_nx;
            end
            unique case (state)
                ST_EMPTY: begin
                    if (done) begin
                        dout      <= word;
                        out_bytes <= word_bytes;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_xfer) begin
                        if (done) begin
                            dout      <= word;
                            out_bytes <= word_bytes;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= ST_EMPTY;
                        end
                    end else if (done) begin
                        hold       <= word;
                        hold_bytes <= word_bytes;
                        in_ready   <= 1'b0;
                        state      <= ST_BOTH;
                    end
                end
                ST_BOTH: begin
                    if (out_xfer) begin
                        dout      <= hold;
                        out_bytes <= hold_bytes;
                        in_ready  <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Directed and random checks of word_packer against a byte-level scoreboard.
module tb_word_packer;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  nb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] dout;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready = 1'b0;

    exp_t        sb[$];
    logic [31:0] mword = '0;
    int          mcnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dout = '0;
    logic [2:0]  prev_nb = '0;
    int          n_vec = 0;
    int          n_err = 0;

    word_packer #(.NBYTES(4), .PAD(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .dout      (dout),
        .out_bytes (out_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample at negedge, then advance to just after the next posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            if (prev_stall) begin
                chk("stable_dout", 64'(dout), 64'(prev_dout));
                chk("stable_bytes", 64'(out_bytes), 64'(prev_nb));
                chk("stable_valid", 64'(out_valid), 64'(1));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_word", 64'(dout), 64'(e.w));
                    chk("sb_bytes", 64'(out_bytes), 64'(e.nb));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            prev_nb    = out_bytes;
            if (in_valid && in_ready) begin
                mword[(3-mcnt)*8 +: 8] = in_data;
                mcnt++;
            end
            if (mcnt == 4 || (flush && mcnt > 0)) begin
                sb.push_back('{w: mword, nb: 3'(mcnt)});
                mword = '0;
                mcnt  = 0;
            end
        end else begin
            sb.delete();
            mword      = '0;
            mcnt       = 0;
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        in_data  = b;
        in_valid = 1'b1;
        flush    = f;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int         sent;
        logic       will_take;
        logic [7:0] cur;

        // Reset state
        step();
        step();
        reset = 1'b1;
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_bytes", 64'(out_bytes), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));

        // Full word, one-cycle latency, single-cycle valid
        out_ready = 1'b1;
        send(8'hAB, 0);
        send(8'hCD, 0);
        send(8'h00, 0);
        chk("t1_not_early", 64'(out_valid), 64'(0));
        send(8'h04, 0);
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_dout", 64'(dout), 64'(32'hABCD0004));
        chk("t1_bytes", 64'(out_bytes), 64'(4));
        step();
        chk("t1_one_cycle", 64'(out_valid), 64'(0));

        // Flushed partial word, then a clean full word
        send(8'hA5, 0);
        send(8'h45, 0);
        do_flush();
        chk("t2_dout", 64'(dout), 64'(32'hA5450000));
        chk("t2_bytes", 64'(out_bytes), 64'(2));
        step();
        send(8'h14, 0);
        send(8'h96, 0);
        send(8'hEE, 0);
        send(8'h01, 0);
        chk("t2b_dout", 64'(dout), 64'(32'h1496EE01));
        chk("t2b_bytes", 64'(out_bytes), 64'(4));
        step();

        // Consumer stall fills the holding slot
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i), 0);
        chk("t3_ready_low", 64'(in_ready), 64'(0));
        chk("t3_dout", 64'(dout), 64'(32'h01020304));
        step();
        step();
        chk("t3_still_low", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        step();
        chk("t3_hold_dout", 64'(dout), 64'(32'h05060708));
        chk("t3_hold_valid", 64'(out_valid), 64'(1));
        chk("t3_ready_back", 64'(in_ready), 64'(1));
        step();
        chk("t3_drained", 64'(out_valid), 64'(0));

        // Byte with flush together, then an empty flush
        send(8'hEE, 1);
        chk("t4_dout", 64'(dout), 64'(32'hEE000000));
        chk("t4_bytes", 64'(out_bytes), 64'(1));
        step();
        do_flush();
        chk("t4_empty_flush", 64'(out_valid), 64'(0));
        step();
        chk("t4_still_empty", 64'(out_valid), 64'(0));

        // Reset during a stall
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 0);
        chk("t5_stalled", 64'(in_ready), 64'(0));
        send(8'h99, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_ready", 64'(in_ready), 64'(1));
        chk("t5_dout", 64'(dout), 64'(0));
        out_ready = 1'b1;
        send(8'h21, 0);
        send(8'h22, 0);
        send(8'h23, 0);
        send(8'h24, 0);
        chk("t5_fresh", 64'(dout), 64'(32'h21222324));
        chk("t5_fresh_n", 64'(out_bytes), 64'(4));
        step();

        // Random traffic against the scoreboard
        sent = 0;
        cur  = 8'($urandom);
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = cur;
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            will_take = in_valid && in_ready;
            step();
            if (will_take) begin
                sent++;
                cur = 8'($urandom);
            end
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        chk("rand_sent", 64'(sent), 64'(1000));
        out_ready = 1'b1;
        do_flush();
        for (int c = 0; c < 100 && (sb.size() > 0 || out_valid); c++) step();
        chk("rand_drain", 64'(sb.size()), 64'(0));
        chk("rand_idle", 64'(out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
